// File: rtl/fpau_pkg.sv
// rtl/fpau_pkg.sv - shared FPAU constants and the multiplier state encoding
package fpau_pkg;

  localparam int FP_WIDTH   = 24;
  localparam int PROD_WIDTH = 2 * FP_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - request/result bundle between the unpack stage and mul_seq
interface mul_seq_if
  import fpau_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] P;
  logic               ovf;

  modport master (
    output start, A, B,
    input  busy, done, P, ovf
  );

  modport slave (
    input  start, A, B,
    output busy, done, P, ovf
  );

endinterface

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one shift-add iteration: conditional add of the multiplicand, then shift right
module mul_step
  import fpau_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
) (
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] reg_a,
  output logic [WIDTH:0]   hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = hi;
    if (lo[0]) begin
      sum = hi + {1'b0, reg_a};
    end
    // The bit shifted out of sum's LSB becomes the new top bit of the low half.
    hi_next = {1'b0, sum[WIDTH:1]};
    lo_next = {sum[0], lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential radix-2 shift-add significand multiplier, fixed WIDTH-cycle iteration
module mul_seq
  import fpau_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic      clk,
  input  logic      rst,
  mul_seq_if.slave  bus
);

  mul_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   reg_a_q, reg_a_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .hi      (hi_q),
    .lo      (lo_q),
    .reg_a   (reg_a_q),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg_a_d = reg_a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          reg_a_d = bus.A;
          hi_d    = '0;
          lo_d    = bus.B;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // After WIDTH shifts hi's extra bit is always zero, so P is the lower 2*WIDTH bits.
          p_d     = {step_hi[WIDTH-1:0], step_lo};
          ovf_d   = step_hi[WIDTH-1];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      reg_a_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg_a_q <= reg_a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.P    = p_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed and random checks of mul_seq against an arithmetic reference
module tb_mul_seq;

  localparam int W = 24;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mul_seq_if #(.WIDTH(W)) bus ();

  mul_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ref_prod(input logic [23:0] a, input logic [23:0] b);
    longint unsigned x, y;
    x = longint'(a);
    y = longint'(b);
    return 48'(x * y);
  endfunction

  // Drives one request, scrambles the operand inputs afterwards, and waits for done.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                        output int lat, output int busy_cnt,
                        output logic [47:0] p, output logic o);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = 24'($urandom);
    bus.B     = 24'($urandom);
    lat      = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_cnt++;
    end
    p = bus.P;
    o = bus.ovf;
    @(posedge clk); #1;
  endtask

  task automatic op_and_check(input string tag, input logic [23:0] a, input logic [23:0] b);
    int          lat, bc;
    logic [47:0] p, exp_p;
    logic        o;
    exp_p = ref_prod(a, b);
    run_op(a, b, lat, bc, p, o);
    check({tag, "_lat"}, 64'(lat), 64'(W));
    check({tag, "_P"}, 64'(p), 64'(exp_p));
    check({tag, "_ovf"}, 64'(o), 64'(exp_p[47]));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(W + 1));
    check({tag, "_idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
    check({tag, "_P_held"}, 64'(bus.P), 64'(exp_p));
  endtask

  initial begin
    int          ndone;
    int          lat;
    logic [47:0] p_seen;
    logic [23:0] ra, rb;

    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {61'd0, bus.busy, bus.done, bus.ovf}, 64'd0);
    check("reset_P", 64'(bus.P), 64'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    op_and_check("one_x_one", 24'h800000, 24'h800000);
    check("one_x_one_const", 64'(bus.P), 64'h400000000000);
    op_and_check("c_x_c", 24'hC00000, 24'hC00000);
    check("c_x_c_const", {15'd0, bus.ovf, bus.P}, {15'd0, 1'b1, 48'h900000000000});
    op_and_check("max_x_max", 24'hFFFFFF, 24'hFFFFFF);
    check("max_x_max_const", 64'(bus.P), 64'hFFFFFE000001);
    op_and_check("max_x_one", 24'hFFFFFF, 24'h000001);
    check("max_x_one_const", 64'(bus.P), 64'h000000FFFFFF);
    op_and_check("zero_a", 24'h000000, 24'hABCDEF);
    op_and_check("zero_b", 24'h123456, 24'h000000);

    for (int i = 0; i < 12; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      if (i % 2 == 0) begin
        ra[23] = 1'b1;
        rb[23] = 1'b1;
      end
      op_and_check($sformatf("rand%0d", i), ra, rb);
      if (i % 2 == 0) check($sformatf("rand%0d_norm_top", i), 64'(bus.P[47:46] != 2'b00), 64'd1);
    end

    // Start re-pulsed while busy, then held high through DONE.
    bus.start = 1'b1;
    bus.A     = 24'h800000;
    bus.B     = 24'h800000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone  = 0;
    p_seen = '0;
    for (int j = 1; j <= W + 1; j++) begin
      if (j == 3 || j == 24) begin
        bus.start = 1'b1;
        bus.A     = 24'hFFFFFF;
        bus.B     = 24'hFFFFFF;
      end
      if (j == 4) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        p_seen = bus.P;
      end
    end
    check("busy_ignore_ndone", 64'(ndone), 64'd1);
    check("busy_ignore_P", 64'(p_seen), 64'h400000000000);
    check("busy_ignore_idle", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("held_start_accept", 64'(bus.busy), 64'd1);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("held_start_lat", 64'(lat), 64'(W));
    check("held_start_P", 64'(bus.P), 64'(ref_prod(24'hFFFFFF, 24'hFFFFFF)));
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run.
    bus.start = 1'b1;
    bus.A     = 24'h9ABCDE;
    bus.B     = 24'hFEDCBA;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_flags", {61'd0, bus.busy, bus.done, bus.ovf}, 64'd0);
    check("async_rst_P", 64'(bus.P), 64'd0);
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    #2 rst = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("async_rst_no_done", 64'(ndone), 64'd0);
    op_and_check("after_rst", 24'hC00000, 24'h800000);
    check("after_rst_const", {15'd0, bus.ovf, bus.P}, {15'd0, 1'b0, 48'h600000000000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
